// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with RV32M-style multiply/divide.
//
// Single-cycle logic, arithmetic and shift ops return one cycle after
// acceptance. MUL* runs on an iterative shift-add multiplier and DIV*/REM*
// run on a restoring divider. Both take XLEN iterations. Signed forms are
// computed on operand magnitudes, and the sign of the result is fixed
// afterwards.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_valid / o_ready     request handshake (i_op, i_a, i_b captured on accept)
//   o_valid / i_ready     result handshake
//   o_result              registered result, held until the next write
//   o_zero                o_result == 0
module alu_seq #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero
);

  localparam logic [4:0] OP_AND    = 5'd0;
  localparam logic [4:0] OP_OR     = 5'd1;
  localparam logic [4:0] OP_ADD    = 5'd2;
  localparam logic [4:0] OP_XOR    = 5'd3;
  localparam logic [4:0] OP_SLL    = 5'd4;
  localparam logic [4:0] OP_SRL    = 5'd5;
  localparam logic [4:0] OP_SUB    = 5'd6;
  localparam logic [4:0] OP_SLT    = 5'd7;
  localparam logic [4:0] OP_SLTU   = 5'd8;
  localparam logic [4:0] OP_SRA    = 5'd9;
  localparam logic [4:0] OP_NOR    = 5'd12;
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU  = 5'd19;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [SHW-1:0]  LAST_IT  = SHW'(XLEN-1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t state, state_nxt;
  logic [SHW-1:0]    cnt;
  logic              accept, busy, last_it;
  logic              is_mul, is_div, div_zero, div_ovf, start_eng;
  logic              a_signed, b_signed, a_neg, b_neg, neg_start;
  logic [XLEN-1:0]   mag_a, mag_b;

  // Engine state: operation, sign fix, multiplicand/divisor, and a shared
  // 2*XLEN accumulator (product, or remainder:quotient).
  logic [4:0]        op_p0;
  logic              neg_p0;
  logic [XLEN-1:0]   mcand_p0;
  logic [2*XLEN-1:0] acc_p0, acc_nxt;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;

  // Single-cycle result. This also covers the divide special cases that bypass
  // the engine: a zero divisor gives all ones (DIV*) or the dividend (REM*).
  // Signed overflow gives the dividend (DIV) or zero (REM).
  function automatic logic [XLEN-1:0] quick_op(input logic [4:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    logic [XLEN-1:0] r;
    sa = a;
    sb = b;
    r  = '0;
    case (op)
      OP_AND:           r = a & b;
      OP_OR:            r = a | b;
      OP_ADD:           r = a + b;
      OP_XOR:           r = a ^ b;
      OP_SLL:           r = a << b[SHW-1:0];
      OP_SRL:           r = a >> b[SHW-1:0];
      OP_SUB:           r = a - b;
      OP_SLT:           r = {{(XLEN-1){1'b0}}, sa < sb};
      OP_SLTU:          r = {{(XLEN-1){1'b0}}, a < b};
      OP_SRA:           r = sa >>> b[SHW-1:0];
      OP_NOR:           r = ~(a | b);
      OP_DIV, OP_DIVU:  r = (b == '0) ? '1 : a;
      OP_REM, OP_REMU:  r = (b == '0) ? a : '0;
      default:          r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

  // Apply the sign correction to the final accumulator and select the result.
  function automatic logic [XLEN-1:0] finish(input logic [4:0] op,
                                             input logic neg,
                                             input logic [2*XLEN-1:0] acc);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, r;
    prod = neg ? -acc : acc;
    quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      OP_MUL:                       r = acc[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: r = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              r = quo;
      OP_REM, OP_REMU:              r = rem;
      default:                      r = '0;
    endcase
    return r;
  endfunction

  assign o_ready = (state == S_IDLE);
  assign o_valid = (state == S_DONE);
  assign o_zero  = (o_result == '0);
  assign accept  = i_valid & o_ready;
  assign busy    = (state == S_MUL) || (state == S_DIV);
  assign last_it = busy && (cnt == LAST_IT);

  // Request decode.
  always_comb begin
    is_mul    = (i_op[4:2] == 3'b100);
    is_div    = (i_op[4:2] == 3'b101);
    div_zero  = is_div && (i_b == '0);
    div_ovf   = ((i_op == OP_DIV) || (i_op == OP_REM)) &&
                (i_a == MOST_NEG) && (i_b == '1);
    start_eng = is_mul || (is_div && !div_zero && !div_ovf);
    a_signed  = (i_op == OP_MULH) || (i_op == OP_MULHSU) ||
                (i_op == OP_DIV)  || (i_op == OP_REM);
    b_signed  = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
    a_neg     = a_signed && i_a[XLEN-1];
    b_neg     = b_signed && i_b[XLEN-1];
    // The sign of the remainder follows the dividend only.
    neg_start = a_neg ^ (b_neg && (i_op != OP_REM));
    mag_a     = magnitude(i_a, a_signed);
    mag_b     = magnitude(i_b, b_signed);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_valid) begin
          if (!start_eng)  state_nxt = S_DONE;
          else if (is_mul) state_nxt = S_MUL;
          else             state_nxt = S_DIV;
        end
      end
      S_MUL, S_DIV: if (cnt == LAST_IT) state_nxt = S_DONE;
      S_DONE:       if (i_ready) state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Iteration step. The multiplier adds the multiplicand into the upper half
  // when the low bit is set, then shifts right. The divider shifts the
  // remainder:quotient pair left and subtracts where no borrow results.
  // div_diff[XLEN] acts as the borrow because the remainder is always below
  // the divisor.
  always_comb begin
    mul_sum  = {1'b0, acc_p0[2*XLEN-1:XLEN]} + (acc_p0[0] ? {1'b0, mcand_p0} : '0);
    div_sh   = acc_p0[2*XLEN-1:XLEN-1];
    div_diff = div_sh - {1'b0, mcand_p0};
    acc_nxt  = acc_p0;
    if (state == S_MUL)
      acc_nxt = {mul_sum, acc_p0[XLEN-1:1]};
    else if (state == S_DIV)
      acc_nxt = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_p0[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], acc_p0[XLEN-2:0], 1'b1};
  end

  // Stage p0: operands captured at acceptance, then iterated.
  always_ff @(posedge i_clk) begin
    if (accept && start_eng) begin
      op_p0    <= i_op;
      neg_p0   <= neg_start;
      mcand_p0 <= is_mul ? mag_a : mag_b;
      acc_p0   <= {{XLEN{1'b0}}, (is_mul ? mag_b : mag_a)};
    end else if (busy) begin
      acc_p0   <= acc_nxt;
    end
  end

  // Iteration counter and output register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt      <= '0;
      o_result <= '0;
    end else if (accept) begin
      cnt <= '0;
      if (!start_eng) o_result <= quick_op(i_op, i_a, i_b);
    end else if (busy) begin
      cnt <= cnt + SHW'(1);
      if (last_it) o_result <= finish(op_p0, neg_p0, acc_nxt);
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU: the next generation of the datapath ALU, generalised to XLEN bits and extended with the RV32M multiply/divide group. Single-cycle logic/arithmetic/shift ops return one cycle after acceptance. MUL*/DIV*/REM* run on an iterative shift-add / restoring-divide engine. Operands enter and results leave through valid/ready handshakes, so the execute stage can stall on a busy unit.

## Interface
- XLEN, 32: datapath width; power of two, ≥ 8.
- SHW, $clog2(XLEN): shift-amount width (derived; not overridden).

- i_clk  input  1  clock; all state changes on rising edge.
- i_rst_n  input  1  reset: one clock; reset is asynchronous and active-low.
- i_valid  input  1  operation request.
- o_ready  output  1  unit can accept a request.
- i_op  input  5  operation code, listed below.
- i_a, i_b  input  XLEN  operands.
- o_valid  output  1  result available.
- i_ready  input  1  consumer takes the result.
- o_result  output  XLEN  result.
- o_zero  output  1  o_result == 0; combinational from o_result.

## Operation
- Legacy codes are unchanged: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (signed), 12 NOR.
- New single-cycle codes: 3 XOR, 4 SLL, 5 SRL, 8 SLTU, 9 SRA.
  - Shift amount is i_b[SHW-1:0]; upper bits of i_b are ignored.
  - SLT/SLTU produce 1 or 0, zero-extended.
- Multi-cycle codes:
  - 16 MUL: low XLEN bits of the product.
  - 17 MULH: high half, signed×signed.
  - 18 MULHSU: high half, signed a × unsigned b.
  - 19 MULHU: high half, unsigned×unsigned.
  - 20 DIV / 21 DIVU: quotient, rounded toward zero.
  - 22 REM / 23 REMU: remainder; sign follows the dividend.
- Any other code: result 0, single-cycle timing.
- Signed mul/div: operands are converted to magnitudes, the unsigned engine runs, then the result sign is corrected. The full product is 2·XLEN bits.
- Special cases complete with single-cycle timing; the engine is not started:
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → i_a.
  - Signed overflow (i_a = most-negative, i_b = −1): DIV → i_a; REM → 0.
- State machine, with transitions:
  - IDLE → DONE on acceptance of a single-cycle op or special case.
  - IDLE → MUL on acceptance of codes 16–19.
  - IDLE → DIV on acceptance of codes 20–23.
  - MUL, DIV → DONE when the iteration counter reaches XLEN−1.
  - DONE → IDLE when i_ready = 1.
- Acceptance = i_valid & o_ready on a rising edge. i_op, i_a and i_b are captured at acceptance; later input changes have no effect.
- o_ready = 1 only in IDLE. o_valid = 1 only in DONE.
- Output register:
  - o_result is registered.
  - It is stable while o_valid = 1 and i_ready = 0.
  - After handoff it keeps the last value until the next result is written.
- Iteration counter is SHW bits. It resets to 0 on entry to MUL/DIV and increments once per cycle.

## Timing
- Reset (async assert, sync release): state IDLE, o_ready = 1, o_valid = 0, o_result = 0, o_zero = 1, counter 0.
- Reset asserted mid-operation aborts the operation; no result is produced.
- Single-cycle op or special case: accepted at edge E0, o_valid = 1 after E0.
- MUL*/DIV*/REM*:
  - Accepted at E0.
  - XLEN iteration edges E1..E(XLEN).
  - o_valid = 1 after edge E(XLEN).
- Handoff: o_valid falls and o_ready rises on the edge where o_valid & i_ready.
  - Earliest next acceptance is the following edge.
  - Sustained throughput for single-cycle ops: one op per 2 cycles.
- i_valid while o_ready = 0 is ignored, not queued; the requester holds i_valid.
- o_valid with i_ready held low: the unit stays in DONE indefinitely with o_result frozen.

## Test plan
- Reset, then run in sequence: ADD 5+7, SUB 3−5, NOR 0,0, SLT −1<1, SLTU −1<1, SRA 0x80000000>>4.
  - Required results: 12; 0xFFFFFFFE; 0xFFFFFFFF; 1; 0; 0xF8000000.
  - o_valid one cycle after each acceptance.
- Multiply, XLEN=32, with i_a = i_b = 0x80000000:
  - MULH → 0x40000000; MULHU → 0x40000000; MUL → 0, o_zero = 1.
  - 7×6 MUL → 42 after exactly 32 cycles.
- Divide, −7 by 2:
  - DIV → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - Each result appears 32 cycles after acceptance.
- Special cases, each with single-cycle latency:
  - DIV 9/0 → 0xFFFFFFFF; REMU 9/0 → 9.
  - DIV 0x80000000/−1 → 0x80000000; REM 0x80000000/−1 → 0.
- Backpressure:
  - Hold i_ready = 0 for 10 cycles after a MUL result; o_result stays stable and o_ready stays 0.
  - Change i_a/i_b during MUL iterations; the result is unaffected.
- Async reset asserted at iteration 15 of a DIV:
  - Outputs go to reset values immediately.
  - After release, a new ADD 1+1 → 2 with normal timing.
